// File: rtl/knn_topk_collector.sv
// knn_topk_collector
// Collects the serial (distance, index) candidate stream of one k-NN query,
// keeps the K nearest entries sorted ascending in a register shift array,
// feeds the K-th best distance back as the pruning threshold, and drains
// the sorted list downstream with a valid/ready handshake at query end.
module knn_topk_collector #(
    parameter int K      = 8,
    parameter int DIST_W = 16,
    parameter int IDX_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIST_W-1:0]        in_dist,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic                     in_last,
    output logic [DIST_W-1:0]        threshold_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIST_W-1:0]        out_dist,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic [$clog2(K+1)-1:0]   count_out
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int PTR_W = $clog2(K);
    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_DRAIN   = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Flat views of the slot registers, used for neighbour shifts and readout.
    logic              slot_valid [K];
    logic [DIST_W-1:0] slot_dist  [K];
    logic [IDX_W-1:0]  slot_idx   [K];

    logic [K-1:0]     le_vec;
    logic [CNT_W-1:0] ins_pos;
    logic             accept;
    logic             insert;
    logic             handshake;
    logic             drain_done;

    assign in_ready   = (state_q == S_COLLECT);
    assign out_valid  = (state_q == S_DRAIN);
    assign out_last   = out_valid && (CNT_W'(rd_ptr_q) == (count_q - CNT_W'(1)));
    assign out_dist   = out_valid ? slot_dist[rd_ptr_q] : '0;
    assign out_idx    = out_valid ? slot_idx[rd_ptr_q]  : '0;
    assign count_out  = count_q;
    assign threshold_out = (count_q == K_CNT) ? slot_dist[K-1] : '1;

    assign accept     = in_valid && in_ready;
    assign insert     = accept && (ins_pos < K_CNT);
    assign handshake  = out_valid && out_ready;
    assign drain_done = handshake && out_last;

    // Insertion position: occupied slots whose distance is <= the candidate.
    // Using <= places a new entry behind equal ones, so earlier arrivals win.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            ins_pos = ins_pos + CNT_W'(le_vec[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_slot
            // Slot gi-1 feeds slot gi on a shift; slot 0 never shifts in.
            localparam int SRC = (gi == 0) ? 0 : gi - 1;

            logic              valid_q, valid_d;
            logic [DIST_W-1:0] dist_q, dist_d;
            logic [IDX_W-1:0]  idx_q, idx_d;

            assign slot_valid[gi] = valid_q;
            assign slot_dist[gi]  = dist_q;
            assign slot_idx[gi]   = idx_q;
            assign le_vec[gi]     = valid_q && (dist_q <= in_dist);

            // Next slot content: clear at end of drain, else write/shift on insert.
            always_comb begin
                valid_d = valid_q;
                dist_d  = dist_q;
                idx_d   = idx_q;
                if (drain_done) begin
                    valid_d = 1'b0;
                end else if (insert) begin
                    if (ins_pos == CNT_W'(gi)) begin
                        valid_d = 1'b1;
                        dist_d  = in_dist;
                        idx_d   = in_idx;
                    end else if (ins_pos < CNT_W'(gi)) begin
                        valid_d = slot_valid[SRC];
                        dist_d  = slot_dist[SRC];
                        idx_d   = slot_idx[SRC];
                    end
                end
            end

            // Slot registers; reset only needs to clear occupancy.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    dist_q  <= '0;
                    idx_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    dist_q  <= dist_d;
                    idx_q   <= idx_d;
                end
            end
        end
    endgenerate

    // Control next-state: occupancy count, read pointer and COLLECT/DRAIN FSM.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (state_q)
            S_COLLECT: begin
                if (insert && (count_q != K_CNT)) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (accept && in_last) begin
                    rd_ptr_d = '0;
                    state_d  = S_DRAIN;
                end
            end
            default: begin
                if (drain_done) begin
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = S_COLLECT;
                end else if (handshake) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
        endcase
    end

    // Control registers; an asserted reset abandons the query at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_COLLECT;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_knn_topk_collector.sv
// Directed bench for knn_topk_collector (K=8, 16-bit distance and index).
module tb_knn_topk_collector;

    localparam int K      = 8;
    localparam int DIST_W = 16;
    localparam int IDX_W  = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DIST_W-1:0] in_dist;
    logic [IDX_W-1:0]  in_idx;
    logic              in_last;
    logic [DIST_W-1:0] threshold_out;
    logic              out_valid;
    logic              out_ready;
    logic [DIST_W-1:0] out_dist;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic [3:0]        count_out;

    int n_vec;
    int n_err;

    knn_topk_collector #(.K(K), .DIST_W(DIST_W), .IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dist       (in_dist),
        .in_idx        (in_idx),
        .in_last       (in_last),
        .threshold_out (threshold_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_dist      (out_dist),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .count_out     (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One accepted candidate per call; outputs settle 1 time unit after the edge.
    task automatic push(input int d, input int idx, input bit last);
        in_valid = 1'b1;
        in_dist  = DIST_W'(d);
        in_idx   = IDX_W'(idx);
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("push dist=%0d idx=%0d last=%0d -> count=%0d thr=%0h",
                 d, idx, last, count_out, threshold_out);
    endtask

    // Check the presented result entry, then complete its handshake.
    task automatic pop(input string tag, input int d, input int idx, input bit last);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".dist"},  32'(out_dist),  32'(d));
        check({tag, ".idx"},   32'(out_idx),   32'(idx));
        check({tag, ".last"},  32'(out_last),  32'(last));
        $display("pop %s dist=%0d idx=%0d last=%0d", tag, out_dist, out_idx, out_last);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_dist   = '0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(in_ready),      32'd1);
        check("rst.out_valid", 32'(out_valid),     32'd0);
        check("rst.out_last",  32'(out_last),      32'd0);
        check("rst.out_dist",  32'(out_dist),      32'd0);
        check("rst.count",     32'(count_out),     32'd0);
        check("rst.thr",       32'(threshold_out), 32'hFFFF);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill below K
        push(50, 0, 0);
        push(20, 1, 0);
        check("fill.thr2", 32'(threshold_out), 32'hFFFF);
        push(40, 2, 1);
        check("fill.count",    32'(count_out),     32'd3);
        check("fill.thr",      32'(threshold_out), 32'hFFFF);
        check("fill.in_ready", 32'(in_ready),      32'd0);
        pop("fill0", 20, 1, 0);
        pop("fill1", 40, 2, 0);
        pop("fill2", 50, 0, 1);
        check("fill.done_valid", 32'(out_valid), 32'd0);
        check("fill.done_ready", 32'(in_ready),  32'd1);
        check("fill.done_count", 32'(count_out), 32'd0);

        // Overflow/eviction, then drops of worse and tied candidates
        for (int i = 0; i < 9; i++) begin
            push(90 - 10 * i, i, 0);
            if (i == 7) check("ovf.thr8", 32'(threshold_out), 32'd90);
        end
        check("ovf.thr9",   32'(threshold_out), 32'd80);
        check("ovf.count9", 32'(count_out),     32'd8);
        push(100, 9, 0);
        check("drop.thr", 32'(threshold_out), 32'd80);
        push(80, 10, 1);
        check("tie_drop.thr",   32'(threshold_out), 32'd80);
        check("tie_drop.count", 32'(count_out),     32'd8);
        for (int i = 0; i < 8; i++) begin
            pop($sformatf("ovf%0d", i), 10 + 10 * i, 8 - i, i == 7);
        end

        // Tie ordering with backpressure on the first result
        push(30, 5, 0);
        push(30, 2, 1);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_dist  = 16'd1;
            in_idx   = 16'd7;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp.valid",    32'(out_valid), 32'd1);
            check("bp.dist",     32'(out_dist),  32'd30);
            check("bp.idx",      32'(out_idx),   32'd5);
            check("bp.in_ready", 32'(in_ready),  32'd0);
            check("bp.count",    32'(count_out), 32'd2);
            $display("stall cycle %0d dist=%0d idx=%0d", c, out_dist, out_idx);
        end
        pop("tie0", 30, 5, 0);
        pop("tie1", 30, 2, 1);
        check("tie.count", 32'(count_out), 32'd0);
        push(70, 4, 1);
        pop("next0", 70, 4, 1);

        // Asynchronous reset mid-drain
        push(7, 0, 0);
        push(3, 1, 0);
        push(9, 2, 0);
        push(1, 3, 0);
        push(5, 4, 1);
        pop("ar0", 1, 3, 0);
        pop("ar1", 3, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("ar.valid",    32'(out_valid),     32'd0);
        check("ar.count",    32'(count_out),     32'd0);
        check("ar.thr",      32'(threshold_out), 32'hFFFF);
        check("ar.in_ready", 32'(in_ready),      32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ar.post_valid", 32'(out_valid), 32'd0);

        // Fresh query after reset, including an all-ones distance
        push(32'hFFFF, 3, 0);
        push(60, 9, 1);
        check("ones.count", 32'(count_out), 32'd2);
        pop("ones0", 60, 9, 0);
        pop("ones1", 32'hFFFF, 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/knn_topk_collector.md
Name: knn_topk_collector

Overview:
- Receiving end of the BDU array's serial result stream: takes one candidate entry (distance, reference index) per cycle and keeps the K nearest entries, sorted ascending by distance.
- Feeds the current K-th best distance back as the pruning threshold for the BDUs.
- On the last candidate of a query it drains the sorted list to the downstream result interface with a valid/ready handshake, then clears itself for the next query.

Parameters:
- K, 8, number of nearest neighbours retained; must be at least 2.
- DIST_W, 16, distance width; matches `B.
- IDX_W, 16, reference index width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  candidate entry present this cycle
- in_ready  out  1  collector accepts candidates; high in COLLECT only
- in_dist  in  DIST_W  candidate distance
- in_idx  in  IDX_W  candidate reference index
- in_last  in  1  candidate is the final one of the current query
- threshold_out  out  DIST_W  current K-th best distance; all-ones while fewer than K entries are held
- out_valid  out  1  sorted result entry presented
- out_ready  in  1  downstream accepts result entry
- out_dist  out  DIST_W  result distance
- out_idx  out  IDX_W  result index
- out_last  out  1  presented entry is the final result of the query
- count_out  out  $clog2(K+1)  number of occupied slots

Behaviour:
- Storage: K slots, each holding a valid bit, dist and idx. Slot 0 is always the smallest distance. Occupied slots are contiguous from slot 0.
- Reset (async, rst=1): all slot valid bits cleared, state=COLLECT, rd_ptr=0. Outputs: in_ready=1, out_valid=0, out_last=0, out_dist=0, out_idx=0, threshold_out=all-ones, count_out=0.
- Accept condition: a candidate is accepted when in_valid && in_ready. in_valid is ignored while in_ready=0.
- Insertion position: p = number of occupied slots with dist <= in_dist, computed in parallel. On a tie, the new entry goes after existing entries, so earlier arrivals win.
- Insertion, completed in one cycle:
  - If p < K: slots p..K-2 shift to p+1..K-1, the old slot K-1 is discarded, and the candidate is written to slot p.
  - If p == K: the candidate is dropped and the slots are unchanged.
  - count_out saturates at K.
- Timing: threshold_out and count_out are registered and reflect an accepted candidate in the cycle after acceptance (1-cycle latency). threshold_out = slot[K-1].dist when count==K, otherwise all-ones.
- State COLLECT: in_ready=1, out_valid=0.
  - Accepted candidate with in_last=1: insert (or drop) as above, set rd_ptr=0, next state DRAIN.
  - in_last=1 without in_valid has no effect.
- State DRAIN: in_ready=0.
  - out_valid=1; out_dist/out_idx = slot[rd_ptr].
  - out_last = (rd_ptr == count-1).
  - On out_valid && out_ready: rd_ptr increments.
  - If out_last was high in that handshake: all slots are cleared, count=0, threshold_out returns to all-ones, next state COLLECT. in_ready becomes high the following cycle.
  - out_ready=0 holds all outputs stable (no change while stalled).
- DRAIN is never entered with count==0: any in_last candidate either is inserted, or is dropped only when count==K.
- Width rules: distances are compared unsigned, DIST_W bits. A candidate whose distance is all-ones is inserted normally if a slot is free.
- Reset mid-DRAIN or mid-COLLECT: the query is abandoned immediately; no partial output is produced after rst deasserts.

Test Plan:
- Fill below K: K=8; insert dist 50,20,40 idx 0,1,2, last on idx2 -> drain emits (20,1),(40,2),(50,0), out_last on the third entry; threshold_out all-ones throughout.
- Overflow/eviction: insert dists 90,80,…,10 (9 entries, idx 0..8) -> the entry with dist 90 is dropped; threshold_out=80 after the 9th acceptance +1 cycle; drain emits 10..80 ascending.
- Drop when worse: with 8 entries held (max 80), insert dist 100 -> slots unchanged, threshold stays 80; insert dist 80 (tie) -> dropped.
- Tie ordering: insert (30,idx5) then (30,idx2), last -> drain order idx5 then idx2.
- Backpressure: during drain, hold out_ready=0 for 3 cycles -> same entry held stable with out_valid=1, in_ready=0, in_valid pulses ignored; after drain completes, the next query starts empty.
- Async reset mid-drain: assert rst after 2 results -> out_valid=0 and count_out=0 immediately, threshold_out all-ones; a new query behaves as after power-up.
